hex_inverter_tester: RTL

HEX_INVERTER_TESTER -- requirements
Module: hex_inverter_tester

---
 rtl/hex_inverter_tester.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hex_inverter_tester.sv
// rtl/hex_inverter_tester.sv - exhaustive 64-vector tester for a hex-inverter part
module hex_inverter_tester #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [5:0] i_dut_out,
  output logic [5:0] o_dut_in,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [5:0] o_fail_mask,
  output logic [6:0] o_err_count,
  output logic [5:0] o_first_fail_vec,
  output logic       o_first_fail_valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [6:0] ERR_MAX     = 7'd64;

  logic [1:0] state_q, state_d;
  logic [5:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] mask_q, mask_d;
  logic [6:0] err_q, err_d;
  logic [5:0] ffv_q, ffv_d;
  logic       ffvalid_q, ffvalid_d;
  logic [5:0] dut_in_q, dut_in_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [5:0] mism;

  assign mism = i_dut_out ^ ~vec_q;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d   = ST_SETTLE;
          vec_d     = 6'd0;
          cnt_d     = 4'd0;
          mask_d    = 6'd0;
          err_d     = 7'd0;
          ffv_d     = 6'd0;
          ffvalid_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        mask_d = mask_q | mism;
        if (|mism) begin
          if (err_q != ERR_MAX) err_d = err_q + 7'd1;
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
        if (vec_q == 6'd63) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 6'd1;
          cnt_d   = 4'd0;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state so pins never glitch on transitions.
    busy_d   = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d   = (state_d == ST_DONE);
    dut_in_d = busy_d ? vec_d : 6'd0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= 6'd0;
      cnt_q     <= 4'd0;
      mask_q    <= 6'd0;
      err_q     <= 7'd0;
      ffv_q     <= 6'd0;
      ffvalid_q <= 1'b0;
      dut_in_q  <= 6'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      dut_in_q  <= dut_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_dut_in           = dut_in_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_pass             = done_q && (mask_q == 6'd0);
  assign o_fail_mask        = mask_q;
  assign o_err_count        = err_q;
  assign o_first_fail_vec   = ffv_q;
  assign o_first_fail_valid = ffvalid_q;

endmodule
